// File: rtl/vga_ram_arb.sv
// Single-port VGA RAM arbiter: fixed-latency display reads take priority, host
// req/ack accesses use the free slots. Optional macro VGA_ARB_BLANK_LOCK_EN.
module vga_ram_arb #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 64
) (
  input  logic              SYSCLK,
  input  logic              RST,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_blank,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_vld,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_starve,
  input  logic              starve_clr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        dbg_host_state
);

  // Host handshake: host_req is a level held (with we/addr/wdata stable) until
  // the one-cycle host_ack strobe; host_req is sampled again from the ack cycle
  // on, so a host with no further work drops it during the ack cycle.
  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_PEND  = 2'd1,
    H_ISSUE = 2'd2,
    H_DATA  = 2'd3
  } host_state_e;

  localparam logic [15:0] MAX_WAIT_V = 16'(MAX_WAIT);

  host_state_e       state_q, state_d;
  logic [15:0]       wait_q, wait_d;
  logic              op_we_q, op_we_d;
  logic              disp_s1_q, disp_s1_d;
  logic              disp_s2_q, disp_s2_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_vld_q, disp_vld_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_starve_q, host_starve_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              port_free;
  logic              host_issue;

`ifdef VGA_ARB_BLANK_LOCK_EN
  // Host traffic is confined to blanking so the visible frame never tears.
  assign port_free = !disp_req && disp_blank;
`else
  logic unused_blank;
  assign unused_blank = disp_blank;
  assign port_free    = !disp_req;
`endif

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    op_we_d      = op_we_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    host_issue   = 1'b0;
    case (state_q)
      H_IDLE: begin
        if (host_req) begin
          if (port_free) begin
            state_d    = H_ISSUE;
            host_issue = 1'b1;
          end else begin
            state_d = H_PEND;
          end
        end
      end
      H_PEND: begin
        if (wait_q != MAX_WAIT_V) wait_d = wait_q + 16'd1;
        if (port_free) begin
          state_d    = H_ISSUE;
          host_issue = 1'b1;
        end
      end
      H_ISSUE: begin
        wait_d  = 16'd0;
        state_d = H_DATA;
      end
      H_DATA: begin
        // RAM data for the host slot is on ram_rdata during this cycle.
        if (!op_we_q) host_rdata_d = ram_rdata;
        host_ack_d = 1'b1;
        state_d    = H_IDLE;
      end
      default: state_d = H_IDLE;
    endcase
    if (host_issue) op_we_d = host_we;
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (disp_req) begin
      ram_addr_d = disp_addr;
    end else if (host_issue) begin
      ram_addr_d  = host_addr;
      ram_we_d    = host_we;
      ram_wdata_d = host_wdata;
    end
  end

  // Two-stage marker follows each display slot through the RAM read latency.
  always_comb begin
    disp_s1_d   = disp_req;
    disp_s2_d   = disp_s1_q;
    disp_vld_d  = disp_s2_q;
    disp_data_d = disp_s2_q ? ram_rdata : disp_data_q;
  end

  always_comb begin
    host_starve_d = host_starve_q;
    if (starve_clr) host_starve_d = 1'b0;
    if (wait_d == MAX_WAIT_V) host_starve_d = 1'b1;
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_q       <= H_IDLE;
      wait_q        <= 16'd0;
      op_we_q       <= 1'b0;
      disp_s1_q     <= 1'b0;
      disp_s2_q     <= 1'b0;
      disp_data_q   <= '0;
      disp_vld_q    <= 1'b0;
      host_ack_q    <= 1'b0;
      host_rdata_q  <= '0;
      host_starve_q <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      op_we_q       <= op_we_d;
      disp_s1_q     <= disp_s1_d;
      disp_s2_q     <= disp_s2_d;
      disp_data_q   <= disp_data_d;
      disp_vld_q    <= disp_vld_d;
      host_ack_q    <= host_ack_d;
      host_rdata_q  <= host_rdata_d;
      host_starve_q <= host_starve_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
    end
  end

  assign disp_data      = disp_data_q;
  assign disp_vld       = disp_vld_q;
  assign host_ack       = host_ack_q;
  assign host_rdata     = host_rdata_q;
  assign host_starve    = host_starve_q;
  assign ram_addr       = ram_addr_q;
  assign ram_we         = ram_we_q;
  assign ram_wdata      = ram_wdata_q;
  assign dbg_host_state = state_q;

endmodule

// File: tb/tb_vga_ram_arb.sv
// Bench for vga_ram_arb: cycle vector table plus directed sequences for
// contention/starvation, reset during a host access and blanking behaviour.
module tb_vga_ram_arb;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_DATA = 2'd3;

  logic          SYSCLK = 1'b0;
  logic          RST;
  logic          disp_req, disp_blank, host_req, host_we, starve_clr;
  logic [AW-1:0] disp_addr, host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] disp_data, host_rdata, ram_wdata, ram_rdata;
  logic          disp_vld, host_ack, host_starve, ram_we;
  logic [AW-1:0] ram_addr;
  logic [1:0]    dbg_host_state;
  logic [DW-1:0] w4_disp_data, w4_host_rdata, w4_ram_wdata, w4_ram_rdata;
  logic          w4_disp_vld, w4_host_ack, w4_host_starve, w4_ram_we;
  logic [AW-1:0] w4_ram_addr;
  logic [1:0]    w4_dbg;

  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          dreq;
    logic [AW-1:0] daddr;
    logic          hreq;
    logic          hwe;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwd;
    logic          evld;
    logic [DW-1:0] eddata;
    logic          eack;
    logic [DW-1:0] ehr;
    logic          ewe;
  } vec_t;
  vec_t vecs[$];

  always #10 SYSCLK = ~SYSCLK;

  always @(posedge SYSCLK) begin
    if (ram_we) mem_a[ram_addr] <= ram_wdata;
    ram_rdata <= mem_a[ram_addr];
    if (w4_ram_we) mem_b[w4_ram_addr] <= w4_ram_wdata;
    w4_ram_rdata <= mem_b[w4_ram_addr];
  end

  vga_ram_arb dut (
    .SYSCLK(SYSCLK), .RST(RST),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_blank(disp_blank),
    .disp_data(disp_data), .disp_vld(disp_vld),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_starve(host_starve), .starve_clr(starve_clr),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_host_state(dbg_host_state)
  );

  vga_ram_arb #(.MAX_WAIT(4)) dut_w4 (
    .SYSCLK(SYSCLK), .RST(RST),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_blank(disp_blank),
    .disp_data(w4_disp_data), .disp_vld(w4_disp_vld),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(w4_host_ack), .host_rdata(w4_host_rdata),
    .host_starve(w4_host_starve), .starve_clr(starve_clr),
    .ram_addr(w4_ram_addr), .ram_we(w4_ram_we), .ram_wdata(w4_ram_wdata),
    .ram_rdata(w4_ram_rdata), .dbg_host_state(w4_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req   = 1'b0;
    disp_addr  = '0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    starve_clr = 1'b0;
  endtask

  task automatic add_vec(input logic dreq, input logic [AW-1:0] daddr,
                         input logic hreq, input logic hwe, input logic [AW-1:0] haddr,
                         input logic [DW-1:0] hwd, input logic evld, input logic [DW-1:0] eddata,
                         input logic eack, input logic [DW-1:0] ehr, input logic ewe);
    vec_t v;
    v.dreq = dreq; v.daddr = daddr; v.hreq = hreq; v.hwe = hwe; v.haddr = haddr;
    v.hwd = hwd; v.evld = evld; v.eddata = eddata; v.eack = eack; v.ehr = ehr; v.ewe = ewe;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem_a[i] = i[DW-1:0];
      mem_b[i] = i[DW-1:0];
    end
    ram_rdata    = '0;
    w4_ram_rdata = '0;

    // Reset held two cycles with every request active.
    RST = 1'b1; disp_blank = 1'b1; starve_clr = 1'b0;
    disp_req = 1'b1; disp_addr = 11'h055;
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h066; host_wdata = 8'h77;
    for (int r = 0; r < 2; r++) begin
      step();
      chk($sformatf("rst%0d disp_vld", r), disp_vld, 0);
      chk($sformatf("rst%0d disp_data", r), disp_data, 0);
      chk($sformatf("rst%0d host_ack", r), host_ack, 0);
      chk($sformatf("rst%0d host_rdata", r), host_rdata, 0);
      chk($sformatf("rst%0d host_starve", r), host_starve, 0);
      chk($sformatf("rst%0d ram_addr", r), ram_addr, 0);
      chk($sformatf("rst%0d ram_we", r), ram_we, 0);
      chk($sformatf("rst%0d ram_wdata", r), ram_wdata, 0);
      chk($sformatf("rst%0d state", r), dbg_host_state, S_IDLE);
    end
    RST = 1'b0;
    idle_inputs();
    step();

    // Display stream 0..15: data returns two edges after each request.
    for (int v = 0; v < 18; v++)
      add_vec(v < 16, 11'(v), 0, 0, 0, 0, v >= 2, 8'(v - 2), 0, 8'h00, 0);
    // Host write 0xA5 to 0x123, then read it back; port idle.
    add_vec(0, 0, 1, 1, 11'h123, 8'hA5, 0, 0, 0, 8'h00, 1);
    add_vec(0, 0, 1, 1, 11'h123, 8'hA5, 0, 0, 0, 8'h00, 0);
    add_vec(0, 0, 1, 1, 11'h123, 8'hA5, 0, 0, 1, 8'h00, 0);
    add_vec(0, 0, 0, 0, 0,       0,     0, 0, 0, 8'h00, 0);
    add_vec(0, 0, 1, 0, 11'h123, 0,     0, 0, 0, 8'h00, 0);
    add_vec(0, 0, 1, 0, 11'h123, 0,     0, 0, 0, 8'h00, 0);
    add_vec(0, 0, 1, 0, 11'h123, 0,     0, 0, 1, 8'hA5, 0);
    add_vec(0, 0, 0, 0, 0,       0,     0, 0, 0, 8'hA5, 0);
    // Display read of an address written by the host one slot earlier.
    add_vec(0, 0,       1, 1, 11'h050, 8'h3C, 0, 0,     0, 8'hA5, 1);
    add_vec(1, 11'h050, 1, 1, 11'h050, 8'h3C, 0, 0,     0, 8'hA5, 0);
    add_vec(0, 0,       1, 1, 11'h050, 8'h3C, 0, 0,     1, 8'hA5, 0);
    add_vec(0, 0,       0, 0, 0,       0,     1, 8'h3C, 0, 8'hA5, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      disp_req = vecs[i].dreq; disp_addr = vecs[i].daddr;
      host_req = vecs[i].hreq; host_we = vecs[i].hwe;
      host_addr = vecs[i].haddr; host_wdata = vecs[i].hwd;
      step();
      chk($sformatf("vec%0d disp_vld", i), disp_vld, vecs[i].evld);
      if (vecs[i].evld) chk($sformatf("vec%0d disp_data", i), disp_data, vecs[i].eddata);
      chk($sformatf("vec%0d host_ack", i), host_ack, vecs[i].eack);
      chk($sformatf("vec%0d host_rdata", i), host_rdata, vecs[i].ehr);
      chk($sformatf("vec%0d ram_we", i), ram_we, vecs[i].ewe);
    end
    idle_inputs();
    step();

    // Host read of 0x077 arrives with a 10-request display burst.
    for (int c = 0; c < 15; c++) begin
      disp_req  = (c < 10);
      disp_addr = 11'(11'h100 + c);
      host_req  = (c <= 12);
      host_we   = 1'b0;
      host_addr = 11'h077;
      step();
      chk($sformatf("cont%0d disp_vld", c), disp_vld, (c >= 2 && c < 12));
      if (c >= 2 && c < 12) chk($sformatf("cont%0d disp_data", c), disp_data, c - 2);
      chk($sformatf("cont%0d host_ack", c), host_ack, (c == 12));
      chk($sformatf("cont%0d ram_we", c), ram_we, 0);
      if (c == 0) chk("cont0 state", dbg_host_state, S_PEND);
      if (c == 10) chk("cont10 ram_addr", ram_addr, 11'h077);
      if (c == 12) chk("cont12 host_rdata", host_rdata, 8'h77);
    end
    chk("cont host_starve max64", host_starve, 0);
    chk("cont host_starve max4", w4_host_starve, 1);
    idle_inputs();
    starve_clr = 1'b1;
    step();
    starve_clr = 1'b0;
    chk("starve_clr max4", w4_host_starve, 0);
    step();
    chk("starve stays clear", w4_host_starve, 0);

    // Reset during H_DATA, with a display fetch also in flight.
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h123;
    step();
    disp_req = 1'b1; disp_addr = 11'h005;
    step();
    chk("rstmid state before", dbg_host_state, S_DATA);
    RST = 1'b1;
    idle_inputs();
    step();
    chk("rstmid host_ack", host_ack, 0);
    chk("rstmid state", dbg_host_state, S_IDLE);
    chk("rstmid disp_vld", disp_vld, 0);
    chk("rstmid host_rdata", host_rdata, 0);
    RST = 1'b0;
    step();
    chk("rstmid host_ack after", host_ack, 0);
    chk("rstmid disp_vld after", disp_vld, 0);
    chk("rstmid state after", dbg_host_state, S_IDLE);

    // Host write while disp_blank is low and no display traffic.
    disp_blank = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h0AA; host_wdata = 8'h5A;
`ifdef VGA_ARB_BLANK_LOCK_EN
    for (int b = 0; b < 5; b++) begin
      step();
      chk($sformatf("blank%0d ram_we", b), ram_we, 0);
      chk($sformatf("blank%0d state", b), dbg_host_state, S_PEND);
    end
    disp_blank = 1'b1;
`endif
    step();
    chk("blank issue ram_we", ram_we, 1);
    chk("blank issue ram_addr", ram_addr, 11'h0AA);
    chk("blank issue ram_wdata", ram_wdata, 8'h5A);
    step();
    chk("blank ack early", host_ack, 0);
    step();
    chk("blank ack", host_ack, 1);
    idle_inputs();
    disp_blank = 1'b1;
    step();
    chk("blank ack drop", host_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
